// File: rtl/uart_tx_fifo_if.sv
// Purpose: groups the producer-side and transmitter-side signals of
// uart_tx_fifo into one bundle.
//   slave  modport: used by uart_tx_fifo (receives pushes, drives tx_start/tx_byte)
//   master modport: used by the environment (producer + uart_tx side)
// Signals:
//   wr_en, wr_data   push request and byte
//   full, empty      FIFO occupancy flags
//   count            bytes stored (excludes the byte in flight)
//   overflow/ovf_clr sticky dropped-push flag and its clear
//   tx_busy          transmitter busy, from uart_tx
//   tx_start/tx_byte one-cycle launch pulse and the byte to send
//   all_sent         FIFO empty, FSM idle and transmitter idle
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  empty;
    logic [ADDR_W:0]       count;
    logic                  overflow;
    logic                  ovf_clr;
    logic                  tx_busy;
    logic                  tx_start;
    logic [DATA_WIDTH-1:0] tx_byte;
    logic                  all_sent;

    modport slave (
        input  wr_en, wr_data, ovf_clr, tx_busy,
        output full, empty, count, overflow, tx_start, tx_byte, all_sent
    );

    modport master (
        output wr_en, wr_data, ovf_clr, tx_busy,
        input  full, empty, count, overflow, tx_start, tx_byte, all_sent
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose: byte FIFO feeding uart_tx. Bytes are pushed at clock rate and
// launched one at a time: a one-cycle tx_start pulse, then the block waits for
// tx_busy to rise and fall again before the next byte may be popped.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous reset, active-high
//   bus   slave modport of uart_tx_fifo_if (push side, flags, uart_tx handshake)
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_t                state_q;
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       count_q,  count_d;
    logic                  ovf_q,    ovf_d;
    logic                  tx_start_q;
    logic [DATA_WIDTH-1:0] tx_byte_q;

    logic full, empty, push_ok, push_drop, pop;

    // Flags come from the registered count, so a pop on the same edge never
    // makes room for a push that arrives while full.
    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign push_ok   = bus.wr_en && !full;
    assign push_drop = bus.wr_en && full;
    assign pop       = (state_q == IDLE) && !empty && !bus.tx_busy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // A dropped push on the same edge as a clear keeps the flag set.
        if (bus.ovf_clr) ovf_d = 1'b0;
        if (push_drop)   ovf_d = 1'b1;
    end

    // Storage array carries no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_byte_q  <= mem_q[rd_ptr_q];
                        tx_start_q <= 1'b1;
                        state_q    <= LAUNCH;
                    end
                end
                LAUNCH:    state_q <= WAIT_BUSY;
                // No timeout: a transmitter that never raises busy stalls here.
                WAIT_BUSY: if (bus.tx_busy)  state_q <= WAIT_DONE;
                WAIT_DONE: if (!bus.tx_busy) state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_byte  = tx_byte_q;
    assign bus.all_sent = empty && (state_q == IDLE) && !bus.tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Purpose: self-checking bench for uart_tx_fifo. A cycle table covers the
// single-byte launch and handshake timing; hand-written sequences cover
// ordering, overflow, simultaneous push/pop, async reset and pointer wrap.
module tb_uart_tx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

    uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       ovf_clr;
        logic       tx_busy;
        logic [4:0] e_count;
        logic       e_full;
        logic       e_empty;
        logic       e_ovf;
        logic       e_start;
        logic [7:0] e_byte;
        logic       e_all;
    } vec_t;

    vec_t vq[$];

    int checks = 0;
    int errors = 0;

    // Transmitter model state
    bit         model_en;
    int         busy_len;
    int         busy_left;
    bit         prev_start;
    logic [7:0] last_byte;
    logic [7:0] rx_q[$];
    int         peak;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic addv(input logic w, input logic [7:0] d, input logic c, input logic b,
                        input logic [4:0] n, input logic f, input logic e, input logic o,
                        input logic s, input logic [7:0] y, input logic a);
        vec_t v;
        v.wr_en = w; v.wr_data = d; v.ovf_clr = c; v.tx_busy = b;
        v.e_count = n; v.e_full = f; v.e_empty = e; v.e_ovf = o;
        v.e_start = s; v.e_byte = y; v.e_all = a;
        vq.push_back(v);
    endtask

    // One clock: sample #1 after the edge, record launches, run the busy model.
    task automatic step();
        @(posedge clk);
        #1;
        if (int'(bus.count) > peak) peak = int'(bus.count);
        if (bus.tx_start) begin
            chk("start_single_cycle", 32'(prev_start), 32'd0);
            rx_q.push_back(bus.tx_byte);
            last_byte = bus.tx_byte;
            if (model_en) begin
                bus.tx_busy = 1'b1;
                busy_left   = busy_len;
            end
        end else begin
            chk("tx_byte_hold", 32'(bus.tx_byte), 32'(last_byte));
            if (model_en && busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) bus.tx_busy = 1'b0;
            end
        end
        prev_start = bus.tx_start;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.ovf_clr = 1'b0;
        bus.tx_busy = 1'b0;
        model_en    = 1'b0;
        busy_left   = 0;
        prev_start  = 1'b0;
        last_byte   = 8'h00;
        peak        = 0;
        rx_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget);
        int cyc = 0;
        while ((rx_q.size() < n || !bus.all_sent) && cyc < budget) begin
            step();
            cyc++;
        end
        chk("drain_done", 32'(rx_q.size() >= n && bus.all_sent), 32'd1);
    endtask

    initial begin
        // Cycle table: wr, data, clr, busy | count, full, empty, ovf, start, byte, all_sent
        addv(1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
        addv(1'b1, 8'h3C, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
        addv(1'b1, 8'h5A, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
        addv(1'b1, 8'h77, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 1'b1);
        addv(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 1'b1);

        // Reset state
        do_reset();
        chk("rst_outputs",
            32'({bus.count, bus.full, bus.empty, bus.overflow, bus.tx_start, bus.tx_byte, bus.all_sent}),
            32'({5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1}));

        // Single byte launch / handshake table
        for (int i = 0; i < vq.size(); i++) begin
            bus.wr_en   = vq[i].wr_en;
            bus.wr_data = vq[i].wr_data;
            bus.ovf_clr = vq[i].ovf_clr;
            bus.tx_busy = vq[i].tx_busy;
            step();
            chk($sformatf("vec%0d", i),
                32'({bus.count, bus.full, bus.empty, bus.overflow, bus.tx_start, bus.tx_byte, bus.all_sent}),
                32'({vq[i].e_count, vq[i].e_full, vq[i].e_empty, vq[i].e_ovf,
                     vq[i].e_start, vq[i].e_byte, vq[i].e_all}));
        end
        bus.wr_en = 1'b0; bus.ovf_clr = 1'b0; bus.tx_busy = 1'b0;

        // Ordering: 16 bytes queued while the transmitter is still busy
        do_reset();
        bus.tx_busy = 1'b1;
        for (int i = 1; i <= 16; i++) push(8'(i));
        chk("order_peak", 32'(peak), 32'd16);
        chk("order_full", 32'(bus.full), 32'd1);
        model_en = 1'b1; busy_len = 20; busy_left = 1;
        run_until(16, 1500);
        chk("order_pulses", 32'(rx_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++)
            chk($sformatf("order_byte%0d", i), 32'(rx_q[i]), 32'(i + 1));

        // Overflow with tx_busy stuck high
        do_reset();
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        push(8'hFF);
        chk("ovf_count", 32'(bus.count), 32'd16);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        bus.ovf_clr = 1'b1;
        push(8'hEE);
        chk("ovf_set_wins", 32'(bus.overflow), 32'd1);
        step();
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", 32'(bus.overflow), 32'd0);

        // Full + IDLE: push and pop on one edge, push is dropped
        bus.tx_busy = 1'b0;
        push(8'hDD);
        chk("simul_full_count", 32'(bus.count), 32'd15);
        chk("simul_full_ovf", 32'(bus.overflow), 32'd1);
        chk("simul_full_byte", 32'({bus.tx_start, bus.tx_byte}), 32'({1'b1, 8'h20}));
        model_en = 1'b1; busy_len = 2; bus.tx_busy = 1'b1; busy_left = 2;
        run_until(16, 600);
        for (int i = 0; i < 16 && i < rx_q.size(); i++)
            chk($sformatf("full_drain%0d", i), 32'(rx_q[i]), 32'(8'h20 + i));

        // Simultaneous push/pop at count 8
        do_reset();
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        bus.tx_busy = 1'b0;
        push(8'h48);
        chk("simul8_count", 32'(bus.count), 32'd8);
        chk("simul8_byte", 32'({bus.tx_start, bus.tx_byte}), 32'({1'b1, 8'h40}));
        model_en = 1'b1; busy_len = 2; bus.tx_busy = 1'b1; busy_left = 2;
        run_until(9, 400);
        for (int i = 0; i < 9 && i < rx_q.size(); i++)
            chk($sformatf("simul8_seq%0d", i), 32'(rx_q[i]), 32'(8'h40 + i));
        chk("simul8_ovf", 32'(bus.overflow), 32'd0);

        // Async reset in WAIT_DONE with 5 bytes queued
        do_reset();
        model_en = 1'b1; busy_len = 30;
        for (int i = 0; i < 6; i++) push(8'(8'h90 + i));
        repeat (3) step();
        chk("t1_pre_count", 32'(bus.count), 32'd5);
        #2;
        model_en = 1'b0;
        bus.tx_busy = 1'b0;
        rst = 1'b1;
        #1;
        chk("t1_async_rst",
            32'({bus.count, bus.full, bus.empty, bus.overflow, bus.tx_start, bus.tx_byte, bus.all_sent}),
            32'({5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1}));

        // Pointer wrap: 40 bytes streamed through
        do_reset();
        model_en = 1'b1; busy_len = 3;
        begin
            int sent = 0;
            int cyc  = 0;
            while (sent < 40 && cyc < 3000) begin
                if (!bus.full) begin
                    bus.wr_en   = 1'b1;
                    bus.wr_data = 8'(8'h30 + sent);
                    sent++;
                end else begin
                    bus.wr_en = 1'b0;
                end
                step();
                cyc++;
            end
            bus.wr_en = 1'b0;
            chk("wrap_pushed", 32'(sent), 32'd40);
        end
        run_until(40, 2000);
        chk("wrap_count", 32'(rx_q.size()), 32'd40);
        for (int i = 0; i < 40 && i < rx_q.size(); i++)
            chk($sformatf("wrap_byte%0d", i), 32'(rx_q[i]), 32'(8'h30 + i));
        chk("wrap_ovf", 32'(bus.overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
